// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared types and constants for the sorter result path
//
// Purpose: element geometry, the sorter result bundle, the streamer FSM
// state, the stream beat layout and helpers that derive group geometry
// from a result channel number.
package sorter_pkg;

  localparam int DATAWIDTH      = 8;
  localparam int MAX_DATALENGTH = 32;

  // Number of parallel sub-sorters per group size; every size covers the
  // same MAX_DATALENGTH elements.
  localparam int NUM_4_SORTER  = MAX_DATALENGTH / 4;
  localparam int NUM_8_SORTER  = MAX_DATALENGTH / 8;
  localparam int NUM_16_SORTER = MAX_DATALENGTH / 16;
  localparam int NUM_32_SORTER = MAX_DATALENGTH / 32;

  // Channel 0 = no result, 1..4 = 4/8/16/32-element groups.
  typedef struct packed {
    logic [NUM_4_SORTER-1:0][3:0][DATAWIDTH-1:0]   data_4;
    logic [NUM_8_SORTER-1:0][7:0][DATAWIDTH-1:0]   data_8;
    logic [NUM_16_SORTER-1:0][15:0][DATAWIDTH-1:0] data_16;
    logic [NUM_32_SORTER-1:0][31:0][DATAWIDTH-1:0] data_32;
    logic [2:0]                                    channel;
  } sorter_top_io_t;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } stream_state_e;

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [2:0]           group;
    logic [4:0]           idx;
    logic                 sign;
    logic                 last;
  } stream_beat_t;

  function automatic logic channel_ok(input logic [2:0] ch);
    return (ch >= 3'd1) && (ch <= 3'd4);
  endfunction

  // Elements per group; 0 for channels that carry no result.
  function automatic logic [5:0] group_size(input logic [2:0] ch);
    case (ch)
      3'd1:    return 6'(MAX_DATALENGTH / NUM_4_SORTER);
      3'd2:    return 6'(MAX_DATALENGTH / NUM_8_SORTER);
      3'd3:    return 6'(MAX_DATALENGTH / NUM_16_SORTER);
      3'd4:    return 6'(MAX_DATALENGTH / NUM_32_SORTER);
      default: return 6'd0;
    endcase
  endfunction

  // Index of the final group (N-1).
  function automatic logic [2:0] last_group(input logic [2:0] ch);
    case (ch)
      3'd1:    return 3'(NUM_4_SORTER - 1);
      3'd2:    return 3'(NUM_8_SORTER - 1);
      3'd3:    return 3'(NUM_16_SORTER - 1);
      3'd4:    return 3'(NUM_32_SORTER - 1);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sorter_result_streamer.sv
// rtl/sorter_result_streamer.sv - serialises a sorter result into per-group top-k beats
//
// Purpose: captures one sorter result (selected channel array, sign, k)
// into a flat buffer and streams the first k elements of every group as
// valid/ready beats, group by group.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   res_valid_i/res_ready_o  result handshake (ready only while idle)
//   res_i, sign_i, k_i       result bundle, sign_ctrl, elements per group
//   out_valid_o/out_ready_i  beat handshake
//   out_data_o, out_group_o, out_idx_o, out_sign_o, out_last_o  beat fields
module sorter_result_streamer
  import sorter_pkg::*;
#(
  parameter int DATAWIDTH      = sorter_pkg::DATAWIDTH,
  parameter int MAX_DATALENGTH = sorter_pkg::MAX_DATALENGTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  sorter_top_io_t       res_i,
  input  logic                 sign_i,
  input  logic [5:0]           k_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] out_data_o,
  output logic [2:0]           out_group_o,
  output logic [4:0]           out_idx_o,
  output logic                 out_sign_o,
  output logic                 out_last_o
);

  stream_state_e        state_q, state_d;
  logic [DATAWIDTH-1:0] data_buf_q [MAX_DATALENGTH];
  logic [DATAWIDTH-1:0] data_buf_d [MAX_DATALENGTH];
  logic                 sign_q;
  logic [5:0]           k_q;
  logic [2:0]           chan_q;
  logic [2:0]           grp_q, grp_d;
  logic [4:0]           idx_q, idx_d;

  logic       capture;
  logic       xfer;
  logic       group_end;
  logic       last_beat;
  logic [5:0] g_new;
  logic [5:0] k_eff;
  logic [4:0] rd_idx;

  // Invalid channels are still accepted while idle; they just never capture.
  assign capture   = (state_q == ST_IDLE) && res_valid_i && channel_ok(res_i.channel);
  assign xfer      = (state_q == ST_STREAM) && out_ready_i;
  assign group_end = (idx_q == 5'(k_q - 6'd1));
  assign last_beat = group_end && (grp_q == last_group(chan_q));
  assign g_new     = group_size(res_i.channel);
  assign k_eff     = ((k_i == 6'd0) || (k_i > g_new)) ? g_new : k_i;
  assign rd_idx    = 5'((int'(grp_q) * int'(group_size(chan_q))) + int'(idx_q));

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_STREAM;
      ST_STREAM: if (xfer && last_beat) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Data and sign are forced to zero outside a stream so
  // the idle/reset view of the beat is all zeros.
  always_comb begin
    res_ready_o = (state_q == ST_IDLE);
    out_valid_o = (state_q == ST_STREAM);
    out_data_o  = (state_q == ST_STREAM) ? data_buf_q[rd_idx] : '0;
    out_group_o = grp_q;
    out_idx_o   = idx_q;
    out_sign_o  = (state_q == ST_STREAM) && sign_q;
    out_last_o  = (state_q == ST_STREAM) && last_beat;
  end

  // Buffer layout is group-major: element e of group g lives at g*G+e.
  always_comb begin
    data_buf_d = data_buf_q;
    if (capture) begin
      case (res_i.channel)
        3'd1: for (int g = 0; g < NUM_4_SORTER; g++)
                for (int e = 0; e < 4; e++)
                  data_buf_d[g*4+e] = DATAWIDTH'(res_i.data_4[g][e]);
        3'd2: for (int g = 0; g < NUM_8_SORTER; g++)
                for (int e = 0; e < 8; e++)
                  data_buf_d[g*8+e] = DATAWIDTH'(res_i.data_8[g][e]);
        3'd3: for (int g = 0; g < NUM_16_SORTER; g++)
                for (int e = 0; e < 16; e++)
                  data_buf_d[g*16+e] = DATAWIDTH'(res_i.data_16[g][e]);
        3'd4: for (int g = 0; g < NUM_32_SORTER; g++)
                for (int e = 0; e < 32; e++)
                  data_buf_d[g*32+e] = DATAWIDTH'(res_i.data_32[g][e]);
        default: ;
      endcase
    end
  end

  // Buffer contents are only observed during a stream, so no reset needed.
  always_ff @(posedge clk_i) begin
    data_buf_q <= data_buf_d;
  end

  // Rank/group counters: idx wraps at k-1 and bumps the group; the final
  // beat returns both to zero ready for the next result.
  always_comb begin
    grp_d = grp_q;
    idx_d = idx_q;
    if (capture) begin
      grp_d = 3'd0;
      idx_d = 5'd0;
    end else if (xfer) begin
      if (last_beat) begin
        grp_d = 3'd0;
        idx_d = 5'd0;
      end else if (group_end) begin
        grp_d = grp_q + 3'd1;
        idx_d = 5'd0;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q <= 1'b0;
      k_q    <= 6'd0;
      chan_q <= 3'd0;
      grp_q  <= 3'd0;
      idx_q  <= 5'd0;
    end else begin
      grp_q <= grp_d;
      idx_q <= idx_d;
      if (capture) begin
        sign_q <= sign_i;
        k_q    <= k_eff;
        chan_q <= res_i.channel;
      end
    end
  end

endmodule
